// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - MIPS 5-stage hazard, forwarding and end-of-program controller (optional macro HAZARD_PERF_EN)
module hazard_ctrl #(
  parameter int HALT_RUN     = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int STALL_MAX    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       JrD,
  input  logic       haltD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       done,
  output logic       stall_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_cycles
`endif
);

  localparam logic [2:0] HALT_SAT   = 3'(HALT_RUN);
  localparam logic [2:0] HALT_LAST  = 3'(HALT_RUN - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
  localparam logic [3:0] STALL_LAST = 4'(STALL_MAX - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t     state, state_nxt;
  logic       init_q;
  logic       boot;
  logic [2:0] halt_cnt;
  logic [2:0] drain_cnt;
  logic [3:0] stall_cnt;
  logic       stall_err_q;
  logic       stall_c, flush_c, done_c;
  logic       lwstall, brstall, br_e, br_m;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // The reset cycles and the first cycle after behave as a flushing bubble.
  assign boot = reset || init_q;

  // Forward selects: MEM result wins over WB result.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!boot) begin
      if (RegWriteM && hit(RsE, WriteRegM))      ForwardAE = 2'b10;
      else if (RegWriteW && hit(RsE, WriteRegW)) ForwardAE = 2'b01;
      if (RegWriteM && hit(RtE, WriteRegM))      ForwardBE = 2'b10;
      else if (RegWriteW && hit(RtE, WriteRegW)) ForwardBE = 2'b01;
      ForwardAD = RegWriteM && hit(RsD, WriteRegM);
      ForwardBD = RegWriteM && hit(RtD, WriteRegM);
    end
  end

  // Load-use and branch-operand hazards; JR only reads Rs.
  always_comb begin
    lwstall = MemtoRegE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE));
    br_e    = RegWriteE && (hit(RsD, WriteRegE) || (BranchD && hit(RtD, WriteRegE)));
    br_m    = MemtoRegM && (hit(RsD, WriteRegM) || (BranchD && hit(RtD, WriteRegM)));
    brstall = (BranchD || JrD) && (br_e || br_m);
  end

  // Next state and stall/flush/done outputs.
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_RUN: begin
        stall_c = lwstall || brstall;
        flush_c = lwstall || brstall;
        if (!boot && haltD && (halt_cnt == HALT_LAST)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        stall_c = 1'b1;
        flush_c = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        stall_c = 1'b1;
        flush_c = 1'b1;
        done_c  = 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
    if (boot) begin
      stall_c = 1'b0;
      flush_c = 1'b1;
      done_c  = 1'b0;
    end
  end

  assign StallF    = stall_c;
  assign StallD    = stall_c;
  assign FlushE    = flush_c;
  assign done      = done_c;
  assign stall_err = stall_err_q && !boot;

  // State register and bubble flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RUN;
      init_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      init_q <= 1'b0;
    end
  end

  // Halt run length and drain length counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_cnt  <= 3'd0;
      drain_cnt <= 3'd0;
    end else begin
      if (state == S_RUN && !boot && haltD && state_nxt == S_RUN)
        halt_cnt <= (halt_cnt < HALT_SAT) ? halt_cnt + 3'd1 : halt_cnt;
      else
        halt_cnt <= 3'd0;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
    end
  end

  // Stall watchdog: sets on the edge that completes STALL_MAX consecutive stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= 4'd0;
      stall_err_q <= 1'b0;
    end else if (state == S_RUN && stall_c) begin
      if (stall_cnt != 4'hF) stall_cnt <= stall_cnt + 4'd1;
      if (stall_cnt == STALL_LAST) stall_err_q <= 1'b1;
    end else begin
      stall_cnt <= 4'd0;
    end
  end

`ifdef HAZARD_PERF_EN
  // Stall and run-length performance counters; cycles freeze once DONE is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls <= 32'd0;
      perf_cycles <= 32'd0;
    end else begin
      if (state == S_RUN && stall_c) perf_stalls <= perf_stalls + 32'd1;
      if (state != S_DONE) perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, JrD, haltD;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       done, stall_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stalls, perf_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JrD(JrD), .haltD(haltD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .done(done), .stall_err(stall_err)
`ifdef HAZARD_PERF_EN
    , .perf_stalls(perf_stalls), .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; JrD = 0; haltD = 0;
  endtask

  task automatic set_lw;
    MemtoRegE = 1; WriteRegE = 8; RtD = 8;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in;
    reset = 1;
    RsE = 5; WriteRegM = 5; RegWriteM = 1;
    set_lw;
    tick; tick;
    check("rst_stall", StallD, 0);
    check("rst_flush", FlushE, 1);
    check("rst_fwd", ForwardAE, 0);
    check("rst_done", done, 0);
    check("rst_err", stall_err, 0);
    reset = 0;
    #1;
    check("boot_stall", StallF, 0);
    check("boot_flush", FlushE, 1);
    check("boot_fwd", ForwardAE, 0);
    tick;
    check("post_boot_fwd", ForwardAE, 2'b10);
    check("post_boot_stall", StallD, 1);
    clr_in; tick;

    // forwarding priority
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    #1 check("fwd_mem", ForwardAE, 2'b10);
    RegWriteM = 0;
    #1 check("fwd_wb", ForwardAE, 2'b01);
    RsE = 0; WriteRegW = 0;
    #1 check("fwd_r0", ForwardAE, 2'b00);
    RtE = 7; WriteRegW = 7;
    #1 check("fwdb_wb", ForwardBE, 2'b01);
    clr_in;

    // load-use
    set_lw;
    #1 check("lw_stallf", StallF, 1);
    check("lw_flush", FlushE, 1);
    tick;
    MemtoRegE = 0;
    #1 check("lw_clear", {StallF, StallD, FlushE}, 3'b000);
    MemtoRegE = 1; WriteRegE = 0; RtD = 0;
    #1 check("lw_r0", StallD, 0);
    clr_in; tick;

    // branch hazards
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    #1 check("br_e", StallD, 1);
    tick;
    RegWriteE = 0; WriteRegE = 0; MemtoRegM = 1; WriteRegM = 3;
    #1 check("br_mload", StallD, 1);
    tick;
    MemtoRegM = 0; RegWriteM = 1;
    #1 check("br_fwd_stall", StallD, 0);
    check("br_fwdad", ForwardAD, 1);
    clr_in;
    JrD = 1; RsD = 3; RtD = 4; RegWriteE = 1; WriteRegE = 4;
    #1 check("jr_rt_ignored", StallD, 0);
    WriteRegE = 3;
    #1 check("jr_rs", StallD, 1);
    set_lw; WriteRegE = 8; RsD = 8; BranchD = 1;
    #1 check("lw_br_both", StallD, 1);
    tick;
    clr_in;
    #1 check("lw_br_single", StallD, 0);
    tick;

    // watchdog: 14 stalls do not trip, 15 do
    set_lw;
    repeat (14) tick;
    clr_in;
    #1 check("wd14", stall_err, 0);
    tick;
    set_lw;
    repeat (14) tick;
    check("wd15_pre", stall_err, 0);
    tick;
    check("wd15", stall_err, 1);
    clr_in;
    tick; tick;
    check("wd_sticky", stall_err, 1);

    // halt: broken run of 4 does not drain, run of 5 does
    haltD = 1;
    repeat (4) tick;
    haltD = 0;
    #1 check("halt4_run", StallD, 0);
    tick;
    haltD = 1; set_lw;
    #1 check("halt_lw", StallD, 1);
    tick;
    MemtoRegE = 0;
    repeat (3) tick;
    check("halt_pre_drain", StallD, 0);
    check("halt_pre_done", done, 0);
    tick;
    clr_in;
    RsE = 5; WriteRegM = 5; RegWriteM = 1;
    #1 check("drain_stall", {StallF, StallD, FlushE}, 3'b111);
    check("drain_fwd", ForwardAE, 2'b10);
    check("drain1_done", done, 0);
    tick;
    check("drain2_done", done, 0);
    tick;
    check("drain3_done", done, 0);
    tick;
    check("done_set", done, 1);
    check("done_stall", {StallF, StallD, FlushE}, 3'b111);
    repeat (3) tick;
    check("done_hold", done, 1);

    reset = 1;
    #1 check("rst_done_clr", done, 0);
    check("rst_err_clr", stall_err, 0);
    tick;
    reset = 0; clr_in;
    #1 check("boot2_flush", FlushE, 1);
    tick;
    check("run_again", {StallD, FlushE, done, stall_err}, 4'b0000);

    // reset in the middle of DRAIN
    haltD = 1;
    repeat (5) tick;
    haltD = 0;
    #1 check("mid_drain", StallD, 1);
    reset = 1;
    tick;
    reset = 0;
    #1 check("mid_rst_boot", {StallD, FlushE}, 2'b01);
    tick;
    check("mid_rst_run", {StallD, FlushE, done}, 3'b000);

`ifdef HAZARD_PERF_EN
    reset = 1; clr_in;
    tick; tick;
    reset = 0;
    tick;
    set_lw; tick; clr_in; tick;
    set_lw; tick; clr_in; tick;
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; tick; clr_in; tick;
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; tick; clr_in; tick;
    haltD = 1;
    repeat (5) tick;
    haltD = 0;
    repeat (3) tick;
    check("perf_done", done, 1);
    check("perf_stalls", perf_stalls, 32'd4);
    check("perf_cycles", perf_cycles, 32'd17);
    repeat (4) tick;
    check("perf_frozen", perf_cycles, 32'd17);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
